// File: rtl/diaosi_scoreboard_pkg.sv
// Shared types and default constants for the diaosi hazard/forwarding scoreboard.
package diaosi_scoreboard_pkg;

  localparam int DEF_DEPTH       = 3;
  localparam int DEF_ALU_LAT     = 1;
  localparam int DEF_LOAD_LAT    = 2;
  localparam int DEF_FLUSH_DEPTH = 1;

  // Forward select: 0 is the register file, k selects the stage holding age k.
  localparam int FWD_W = $clog2(DEF_DEPTH + 1);
  typedef logic [FWD_W-1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REGFILE = '0;

  // Age is stored wide enough for any practical DEPTH (up to 255).
  localparam int AGE_W = 8;
  typedef logic [AGE_W-1:0] age_t;

  typedef struct packed {
    logic valid;
    age_t age;
    logic is_load;
  } sb_entry_t;

endpackage

// File: rtl/diaosi_scoreboard_sb_entry.sv
// One tracked register: set on issue, aged every cycle, squashed by flush while young.
module diaosi_sb_entry
  import diaosi_scoreboard_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
  input  logic      clk,
  input  logic      srst,
  input  logic      set,
  input  logic      set_load,
  input  logic      flush,
  output sb_entry_t ent
);

  sb_entry_t ent_reg;
  sb_entry_t ent_next;

  always_comb begin
    ent_next = ent_reg;
    // Flush looks at the pre-aging age, then survivors advance.
    if (flush && ent_reg.valid && (int'(ent_reg.age) <= FLUSH_DEPTH)) begin
      ent_next = '0;
    end
    if (ent_next.valid) begin
      if (int'(ent_next.age) >= DEPTH) begin
        ent_next = '0;
      end else begin
        ent_next.age = ent_next.age + age_t'(1);
      end
    end
    // A new producer replaces whatever was in flight, including one retiring now.
    if (set) begin
      ent_next.valid   = 1'b1;
      ent_next.age     = age_t'(1);
      ent_next.is_load = set_load;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ent_reg <= '0;
    end else begin
      ent_reg <= ent_next;
    end
  end

  assign ent = ent_reg;

endmodule

// File: rtl/diaosi_scoreboard.sv
// Decode-stage scoreboard: load-use stall and per-operand forward selects.
// Optional SCOREBOARD_STATS_EN adds a saturating stall-cycle counter output.
module diaosi_scoreboard
  import diaosi_scoreboard_pkg::*;
#(
  parameter int NREGS       = 32,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ALU_LAT     = DEF_ALU_LAT,
  parameter int LOAD_LAT    = DEF_LOAD_LAT,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         issue_valid,
  input  logic                         issue_wen,
  input  logic                         issue_load,
  input  logic [$clog2(NREGS)-1:0]     issue_rd,
  input  logic [$clog2(NREGS)-1:0]     rs_idx,
  input  logic [$clog2(NREGS)-1:0]     rt_idx,
  input  logic                         rs_used,
  input  logic                         rt_used,
  input  logic                         flush,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]                  stall_count
`endif
);

  localparam int RW = $clog2(NREGS);
  localparam int FW = $clog2(DEPTH + 1);

  sb_entry_t entries [NREGS];
  logic      accept;
  logic      stall_a;
  logic      stall_b;

  assign accept     = issue_valid & ~stall & ~flush;
  assign entries[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_entry
      diaosi_sb_entry #(
        .DEPTH       (DEPTH),
        .FLUSH_DEPTH (FLUSH_DEPTH)
      ) u_entry (
        .clk      (CLK),
        .srst     (RST),
        .set      (accept && issue_wen && (issue_rd == RW'(gi))),
        .set_load (issue_load),
        .flush    (flush),
        .ent      (entries[gi])
      );
    end
  endgenerate

  // Returns {stall, forward select} for one operand.
  function automatic logic [FW:0] lookup(input sb_entry_t e, input logic used,
                                         input logic [RW-1:0] idx);
    logic [FW:0] r;
    int          req;
    r   = '0;
    req = e.is_load ? LOAD_LAT : ALU_LAT;
    if (used && (idx != '0) && e.valid) begin
      if (int'(e.age) < req) r[FW] = 1'b1;
      else                   r[FW-1:0] = FW'(e.age);
    end
    return r;
  endfunction

  always_comb begin
    {stall_a, fwd_a} = lookup(entries[rs_idx], rs_used, rs_idx);
    {stall_b, fwd_b} = lookup(entries[rt_idx], rt_used, rt_idx);
  end

  assign stall = stall_a | stall_b;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_count_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count_reg <= '0;
    end else if (stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
      stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_diaosi_scoreboard.sv
// Randomized bench for diaosi_scoreboard against a timestamp-based reference model.
module tb_diaosi_scoreboard;

  localparam int NREGS       = 32;
  localparam int DEPTH       = 3;
  localparam int ALU_LAT     = 1;
  localparam int LOAD_LAT    = 2;
  localparam int FLUSH_DEPTH = 1;
  localparam int RW          = $clog2(NREGS);
  localparam int FW          = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_wen = 1'b0;
  logic          issue_load = 1'b0;
  logic [RW-1:0] issue_rd = '0;
  logic [RW-1:0] rs_idx = '0;
  logic [RW-1:0] rt_idx = '0;
  logic          rs_used = 1'b0;
  logic          rt_used = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic [FW-1:0] fwd_a;
  logic [FW-1:0] fwd_b;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]   stall_count;
`endif

  diaosi_scoreboard #(
    .NREGS(NREGS), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT),
    .LOAD_LAT(LOAD_LAT), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_load  (issue_load),
    .issue_rd    (issue_rd),
    .rs_idx      (rs_idx),
    .rt_idx      (rt_idx),
    .rs_used     (rs_used),
    .rt_used     (rt_used),
    .flush       (flush),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  // Model: cycle in which each register's youngest producer was issued.
  int issue_cyc [NREGS];
  bit is_ld [NREGS];
  int exp_cnt = 0;

  logic          last_stall;
  logic [FW-1:0] last_fa;
  logic [FW-1:0] last_fb;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int m_age(input int r);
    return cyc - issue_cyc[r];
  endfunction

  function automatic bit m_valid(input int r);
    return (r != 0) && (m_age(r) >= 1) && (m_age(r) <= DEPTH);
  endfunction

  function automatic void m_operand(input int r, input bit used, output bit st, output int fw);
    st = 1'b0;
    fw = 0;
    if (used && m_valid(r)) begin
      if (m_age(r) < (is_ld[r] ? LOAD_LAT : ALU_LAT)) st = 1'b1;
      else fw = m_age(r);
    end
  endfunction

  task automatic cycle(input bit rst, input bit iv, input bit wen, input bit ld, input int rd,
                       input int rs, input int rt, input bit rsu, input bit rtu, input bit fl);
    bit sa, sb, est;
    int fa, fb;
    @(negedge CLK);
    RST = rst; issue_valid = iv; issue_wen = wen; issue_load = ld;
    issue_rd = RW'(rd); rs_idx = RW'(rs); rt_idx = RW'(rt);
    rs_used = rsu; rt_used = rtu; flush = fl;
    #1;
    m_operand(rs, rsu, sa, fa);
    m_operand(rt, rtu, sb, fb);
    est = sa | sb;
    last_stall = stall; last_fa = fwd_a; last_fb = fwd_b;
    $display("cyc %0d rst=%0b iv=%0b wen=%0b ld=%0b rd=%0d rs=%0d/%0b rt=%0d/%0b fl=%0b -> stall=%0b fa=%0d fb=%0d",
             cyc, rst, iv, wen, ld, rd, rs, rsu, rt, rtu, fl, stall, fwd_a, fwd_b);
    check_val("stall", {31'd0, stall}, {31'd0, est});
    check_val("fwd_a", 32'(fwd_a), 32'(fa));
    check_val("fwd_b", 32'(fwd_b), 32'(fb));
`ifdef SCOREBOARD_STATS_EN
    check_val("stall_count", stall_count, 32'(exp_cnt));
`endif
    @(posedge CLK);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) issue_cyc[r] = -100;
      exp_cnt = 0;
    end else begin
      if (est) exp_cnt++;
      if (fl) begin
        for (int r = 1; r < NREGS; r++)
          if (m_valid(r) && m_age(r) <= FLUSH_DEPTH) issue_cyc[r] = -100;
      end else if (iv && !est && wen && rd != 0) begin
        issue_cyc[rd] = cyc;
        is_ld[rd]     = ld;
      end
    end
    cyc++;
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      issue_cyc[r] = -100;
      is_ld[r]     = 1'b0;
    end
    // Reset held with issue attempts: nothing may be tracked.
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 5, 5, 5, 1, 1, 0);
    check_val("rst_stall", {31'd0, last_stall}, 32'd0);
    check_val("rst_fwd_a", 32'(last_fa), 32'd0);

    // ALU producer r5 ages through every stage, then retires.
    cycle(0, 1, 1, 0, 5, 0, 0, 0, 0, 0);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      cycle(0, 0, 0, 0, 0, 5, 0, 1, 0, 0);
      check_val("alu_fwd_a", 32'(last_fa), (k <= DEPTH) ? 32'(k) : 32'd0);
    end

    // Load-use on r7: one stall cycle, then forward from age 2.
    cycle(0, 1, 1, 1, 7, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 7, 0, 1, 0);
    check_val("lu_stall", {31'd0, last_stall}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 7, 0, 1, 0);
    check_val("lu_stall_clr", {31'd0, last_stall}, 32'd0);
    check_val("lu_fwd_b", 32'(last_fb), 32'd2);

    // Back-to-back writes of r3: the youngest producer wins.
    cycle(0, 1, 1, 0, 3, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 3, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 3, 0, 1, 0, 0);
    check_val("rewrite_fwd_a", 32'(last_fa), 32'd1);

    // Flush squashes young load r9 and drops the same-cycle issue of r11.
    cycle(0, 1, 1, 1, 9, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 11, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 9, 11, 1, 1, 0);
    check_val("flush_stall", {31'd0, last_stall}, 32'd0);
    check_val("flush_fwd_a", 32'(last_fa), 32'd0);
    check_val("flush_fwd_b", 32'(last_fb), 32'd0);

    // Register 0 is never tracked.
    cycle(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    check_val("r0_stall", {31'd0, last_stall}, 32'd0);
    check_val("r0_fwd_a", 32'(last_fa), 32'd0);

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/diaosi_scoreboard.md
Name: diaosi_scoreboard

Overview:
- Parametrised hazard and forwarding scoreboard for the pipelined core, sitting in the decode stage.
- Tracks in-flight register writes by age, then drives the load-use stall and per-operand forward-select codes for a pipeline of configurable depth.
- Replaces the fixed two-source, fixed-depth forwarding scheme. Adds load-latency-aware stalling, flush handling, and an arbitrary number of forwarding stages.

Parameters:
- NREGS, 32, architectural registers; register 0 is never tracked.
- DEPTH, 3, stages from issue to writeback; an entry's age runs 1..DEPTH.
- ALU_LAT, 1, minimum age at which an ALU result can be forwarded.
- LOAD_LAT, 2, minimum age at which a load result can be forwarded.
- FLUSH_DEPTH, 1, on flush, entries with age <= FLUSH_DEPTH are squashed.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous, active-high reset
- issue_valid  in  1  decode is issuing an instruction this cycle
- issue_wen  in  1  the issued instruction writes a register
- issue_load  in  1  the issued instruction is a load
- issue_rd  in  $clog2(NREGS)  destination register
- rs_idx  in  $clog2(NREGS)  source A index
- rt_idx  in  $clog2(NREGS)  source B index
- rs_used  in  1  source A is read
- rt_used  in  1  source B is read
- flush  in  1  squash young entries
- stall  out  1  hold decode and insert a bubble
- fwd_a  out  $clog2(DEPTH+1)  forward select for A; 0 = register file, k = stage at age k
- fwd_b  out  $clog2(DEPTH+1)  forward select for B, same encoding

Behaviour:
- Per-register state: valid, age (0..DEPTH), is_load.
- Reset state:
  - All entries invalid with age 0.
  - stall=0, fwd_a=0, fwd_b=0, all combinational from state.
- Each clock, every valid entry advances age by 1.
  - An entry leaving age DEPTH is cleared; this is writeback.
  - The register file is write-before-read, so the value is read directly that cycle.
- Issue accepted when issue_valid=1, stall=0 and flush=0.
  - If issue_wen=1 and issue_rd!=0: the entry for issue_rd becomes valid with age 1 and is_load=issue_load.
  - This overwrites any older in-flight entry for the same register, so the youngest producer wins.
- Operand check for A (B is identical), when rs_used=1, rs_idx!=0 and the entry is valid:
  - Required latency = LOAD_LAT if is_load, else ALU_LAT.
  - If age < required latency: stall=1 and fwd_a=0.
  - Otherwise fwd_a=age.
  - Unused operands, register 0 or invalid entries give fwd=0.
- stall is the OR of the A and B stall conditions.
  - While stall=1, issue is ignored and existing entries still age.
  - The stall therefore self-clears after at most LOAD_LAT-1 cycles.
- Flush:
  - Entries with age <= FLUSH_DEPTH are invalidated before aging that cycle.
  - Flush has priority over issue; an issue in the same cycle is dropped.
- Simultaneous issue and writeback of the same register: the new entry (age 1) wins; the retiring one is discarded.
- Reset mid-operation clears every entry on the next edge; no partial state survives.
- Outputs are purely combinational from the registered state plus the current-cycle index inputs, with zero-cycle latency.

Optional Feature:
- Macro SCOREBOARD_STATS_EN.
- When defined, adds output stall_count [31:0]:
  - Counts cycles with stall=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by RST.
- When not defined, the port and counter are absent and there is no other change.

Decomposition:
- Shared package gets:
  - A generalised forward-select typedef whose width is derived from DEPTH, with value 0 named as the register-file source.
  - A struct holding valid, age and is_load.
  - Default latency constants ALU_LAT and LOAD_LAT.
- One natural sub-module, diaosi_sb_entry:
  - Per-register aging, set and flush logic.
  - Instantiated NREGS-1 times by generate.
- Top-level block holds the operand lookup muxes and the stall OR.

Test Plan:
- Reset, then hold RST high with issue_valid=1 -> stall=0, fwd_a=fwd_b=0 throughout.
- ALU producer: issue rd=5 (non-load); next cycle rs_idx=5, rs_used=1 -> stall=0, fwd_a=1; following cycle fwd_a=2; after DEPTH cycles fwd_a=0.
- Load-use: issue load rd=7; next cycle rt_idx=7 -> stall=1 for 1 cycle, then fwd_b=2, stall=0.
- Rewrite: issue rd=3 twice on consecutive cycles; read r3 -> fwd_a=1 (youngest producer), never 2.
- Flush: issue load rd=9, assert flush the next cycle -> entry cleared, a read of r9 gives fwd=0 and stall=0; an issue in the flush cycle is dropped.
- Register 0: issue rd=0 then read r0 -> fwd=0, stall=0. With SCOREBOARD_STATS_EN, stall_count increments exactly once per stalled cycle.
